// File: rtl/nibble_add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_add_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add_seq_adder.sv
// 4-bit ripple adder shared by the sequencer, one nibble per clock.
module adder
  import nibble_add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] input1,
  input  logic [NIBBLE_W-1:0] input2,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  assign {carry_out, sum} = (NIBBLE_W+1)'(input1) + (NIBBLE_W+1)'(input2)
                          + (NIBBLE_W+1)'(carry_in);

endmodule

// File: rtl/nibble_add_seq.sv
// WIDTH-bit add (and, with NIBBLE_SEQ_SUB_EN defined, subtract) computed one
// nibble per clock through a single shared 4-bit adder.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic [WIDTH-1:0]    sum_ext;

`ifdef NIBBLE_SEQ_SUB_EN
  // Subtraction is a + ~b + ~borrow_in; carry_out then reads as "no borrow".
  assign b_eff   = sub ? ~op_b : op_b;
  assign cin_eff = sub ? ~carry_in : carry_in;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = op_b;
  assign cin_eff    = carry_in;
`endif

  adder u_adder (
    .input1    (a_sh_q[NIBBLE_W-1:0]),
    .input2    (b_sh_q[NIBBLE_W-1:0]),
    .carry_in  (carry_q),
    .sum       (nib_sum),
    .carry_out (nib_cout)
  );

  assign sum_ext = WIDTH'(nib_sum);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        // Sums enter at the top so the LS nibble lands at bit 0 after NIBBLES steps.
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        result_d = (result_q >> NIBBLE_W) | (sum_ext << (WIDTH - NIBBLE_W));
        carry_d  = nib_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIBBLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign carry_out   = carry_q;
  assign ovf         = (a_msb_q == b_msb_q) && (result_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq (WIDTH=16).
module tb_nibble_add_seq;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf;

  int checkCount = 0;
  int passCount  = 0;

  nibble_add_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .carry_in    (carry_in),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for exactly one accept edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic s);
    op_a        = a;
    op_b        = b;
    carry_in    = cin;
    sub         = s;
    start_valid = 1'b1;
    stepCycle();
    start_valid = 1'b0;
    op_a        = ~a;
    op_b        = ~b;
    carry_in    = ~cin;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 20) begin
      stepCycle();
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, input logic s,
                       input logic [WIDTH-1:0] expRes, input logic expCout,
                       input logic expOvf);
    int cycles;
    checkOutput({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    applyStimulus(a, b, cin, s);
    waitResult(cycles);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd4);
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_carry_out"}, 32'(carry_out), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  task automatic drainResult(input string tag);
    res_ready = 1'b1;
    stepCycle();
    res_ready = 1'b0;
    checkOutput({tag, "_drain_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_drain_start_ready"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] heldResult;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    carry_in    = 1'b0;
    sub         = 1'b0;
    res_ready   = 1'b0;
    #12;
    checkOutput("reset_start_ready", 32'(start_ready), 32'd1);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_carry_out", 32'(carry_out), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    runOp("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    drainResult("add_basic");

    runOp("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drainResult("carry_ripple");

    runOp("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drainResult("pos_ovf");

    runOp("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result held while a competing request waits.
    heldResult  = result;
    op_a        = 16'h1111;
    op_b        = 16'h2222;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("bp_result", 32'(result), 32'(heldResult));
      checkOutput("bp_start_ready", 32'(start_ready), 32'd0);
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
    end
    start_valid = 1'b0;
    drainResult("bp");
    runOp("after_bp", 16'h0101, 16'h0202, 1'b1, 1'b0, 16'h0304, 1'b0, 1'b0);
    drainResult("after_bp");

    // Asynchronous reset partway through RUN.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_start_ready", 32'(start_ready), 32'd1);
    checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_carry_out", 32'(carry_out), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf), 32'd0);
    #2;
    rst_n = 1'b1;
    stepCycle();
    runOp("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drainResult("post_rst");

`ifdef NIBBLE_SEQ_SUB_EN
    runOp("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`else
    runOp("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif
    drainResult("sub");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
